// File: rtl/intc_pkg.sv
// Shared types for the interrupt controller: register offsets, FSM states,
// source ID width and the STATUS register layout.
package intc_pkg;

  localparam int INTC_ID_W = 5;

  typedef enum logic [1:0] {
    PENDING = 2'd0,
    ENABLE  = 2'd1,
    CLAIM   = 2'd2,
    STATUS  = 2'd3
  } intc_reg_e;

  typedef enum logic {
    IDLE       = 1'b0,
    IN_SERVICE = 1'b1
  } intc_state_e;

  // STATUS word: bit0 in_service, bits[12:8] active source ID
  typedef struct packed {
    logic [18:0]          rsvd_hi;
    logic [INTC_ID_W-1:0] active_id;
    logic [6:0]           rsvd_lo;
    logic                 in_service;
  } intc_status_t;

  function automatic logic [31:0] pack_status(input intc_state_e st,
                                              input logic [INTC_ID_W-1:0] id);
    intc_status_t s;
    s            = '0;
    s.in_service = (st == IN_SERVICE);
    s.active_id  = id;
    return s;
  endfunction

endpackage

// File: rtl/intc_src_detect.sv
// Per-source rising-edge detector. With INTC_SYNC_EN defined the source first
// passes a 2-flop synchronizer; otherwise it must already be clk-synchronous.
module intc_src_detect
  import intc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic src,
  output logic rise
);

`ifdef INTC_SYNC_EN
  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= src;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign rise = sync2_reg & ~prev_reg;
`else
  logic prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg <= 1'b0;
    end else begin
      prev_reg <= src;
    end
  end

  // Combinational so pending latches on the very edge that first samples src high
  assign rise = src & ~prev_reg;
`endif

endmodule

// File: rtl/intc.sv
// Memory-mapped interrupt controller with non-nested claim/complete handshake.
// Optional input synchronizers are enabled by defining INTC_SYNC_EN.
module intc
  import intc_pkg::*;
#(
  parameter int          NUM_SRC   = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_fff0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        addr,
  input  logic [31:0]        data_in,
  input  logic               mem_rd,
  input  logic               mem_wr,
  output logic [31:0]        data_out,
  output logic               oe,
  input  logic [NUM_SRC-1:0] src,
  output logic               irq
);

  logic [31:0]          addr_off;
  logic                 in_range;
  intc_reg_e            reg_sel;
  logic                 rd_hit;
  logic                 wr_hit;

  logic [NUM_SRC-1:0]   pending_reg;
  logic [NUM_SRC-1:0]   pending_next;
  logic [NUM_SRC-1:0]   enable_reg;
  logic [NUM_SRC-1:0]   enable_next;
  logic [NUM_SRC-1:0]   rise;
  logic [NUM_SRC-1:0]   masked;
  logic [NUM_SRC-1:0]   w1c_mask;
  logic [NUM_SRC-1:0]   claim_clr;

  intc_state_e          state_reg;
  intc_state_e          state_next;
  logic [INTC_ID_W-1:0] active_id_reg;
  logic [INTC_ID_W-1:0] active_id_next;

  logic [INTC_ID_W-1:0] winner_id;
  logic                 any_masked;
  logic                 claim_fire;
  logic                 complete_fire;
  logic                 unused_data;

  // Unsigned wrap makes addresses below BASE_ADDR fall out of range too
  assign addr_off = addr - BASE_ADDR;
  assign in_range = (addr_off[31:2] == 30'd0);
  assign reg_sel  = intc_reg_e'(addr_off[1:0]);
  assign rd_hit   = mem_rd & in_range;
  assign wr_hit   = mem_wr & in_range;

  assign masked     = pending_reg & enable_reg;
  assign any_masked = |masked;
  assign w1c_mask   = (wr_hit && reg_sel == PENDING) ? data_in[NUM_SRC-1:0] : '0;

  assign claim_fire    = rd_hit && (reg_sel == CLAIM) && (state_reg == IDLE) && any_masked;
  assign complete_fire = wr_hit && (reg_sel == CLAIM) && (state_reg == IN_SERVICE) &&
                         (data_in[INTC_ID_W-1:0] == active_id_reg);

  // Fixed priority: lowest index wins, so scan downward and keep the last hit
  always_comb begin
    winner_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (masked[i]) begin
        winner_id = INTC_ID_W'(i + 1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      intc_src_detect u_det (
        .clk  (clk),
        .rst  (rst),
        .src  (src[gi]),
        .rise (rise[gi])
      );

      assign claim_clr[gi] = claim_fire && (winner_id == INTC_ID_W'(gi + 1));
      // A new edge beats any clear landing on the same cycle
      assign pending_next[gi] = rise[gi] |
                                (pending_reg[gi] & ~w1c_mask[gi] & ~claim_clr[gi]);
    end
  endgenerate

  assign enable_next = (wr_hit && reg_sel == ENABLE) ? data_in[NUM_SRC-1:0] : enable_reg;

  always_comb begin
    state_next     = state_reg;
    active_id_next = active_id_reg;
    if (claim_fire) begin
      state_next     = IN_SERVICE;
      active_id_next = winner_id;
    end else if (complete_fire) begin
      state_next     = IDLE;
      active_id_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg   <= '0;
      enable_reg    <= '0;
      state_reg     <= IDLE;
      active_id_reg <= '0;
    end else begin
      pending_reg   <= pending_next;
      enable_reg    <= enable_next;
      state_reg     <= state_next;
      active_id_reg <= active_id_next;
    end
  end

  // Read mux reflects pre-write state, so a combined rd/wr returns old data
  always_comb begin
    data_out = '0;
    if (rd_hit) begin
      unique case (reg_sel)
        PENDING: data_out = 32'(pending_reg);
        ENABLE:  data_out = 32'(enable_reg);
        CLAIM:   data_out = (state_reg == IDLE && any_masked) ? 32'(winner_id) : 32'd0;
        STATUS:  data_out = pack_status(state_reg, active_id_reg);
        default: data_out = '0;
      endcase
    end
  end

  assign oe  = rd_hit;
  assign irq = (state_reg == IDLE) && any_masked;

  assign unused_data = ^data_in;

endmodule

// File: tb/tb_intc.sv
// Self-checking bench for intc: directed test-plan sequence plus random traffic,
// all checked every cycle against a behavioural model of the register rules.
module tb_intc;

  localparam int          NSRC = 16;
  localparam logic [31:0] BASE = 32'h0000_fff0;
`ifdef INTC_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [31:0]     addr = '0;
  logic [31:0]     data_in = '0;
  logic            mem_rd = 1'b0;
  logic            mem_wr = 1'b0;
  logic [31:0]     data_out;
  logic            oe;
  logic [NSRC-1:0] src = '0;
  logic            irq;

  int vectors = 0;
  int miscompares = 0;

  intc #(.NUM_SRC(NSRC), .BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .data_out (data_out),
    .oe       (oe),
    .src      (src),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Model state: pending/enable bit sets, service flag, active ID, src history
  bit [NSRC-1:0] m_pend, m_en, h1, h2;
  bit            m_svc;
  bit [4:0]      m_act;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, want, $time);
    end
  endtask

  // Per-cycle compare + model advance (inputs are stable from posedge+1 on)
  always @(negedge clk) begin
    bit [31:0]     off;
    bit            inr, any, e_irq, e_oe;
    bit [31:0]     e_do;
    int            win;
    bit [NSRC-1:0] rs, n_pend, n_en;
    bit            n_svc;
    bit [4:0]      n_act;

    if (rst) begin
      m_pend = '0; m_en = '0; m_svc = 1'b0; m_act = '0; h1 = '0; h2 = '0;
    end
    off = addr - BASE;
    inr = (off < 4);
    win = 0;
    for (int i = NSRC - 1; i >= 0; i--) if (m_pend[i] && m_en[i]) win = i;
    any   = |(m_pend & m_en);
    e_irq = !m_svc && any;
    e_oe  = mem_rd && inr;
    e_do  = 0;
    if (e_oe) begin
      case (off)
        0: e_do = 32'(m_pend);
        1: e_do = 32'(m_en);
        2: e_do = (!m_svc && any) ? 32'(win + 1) : 32'd0;
        default: e_do = {19'd0, m_act, 7'd0, m_svc};
      endcase
    end
    check("irq", 32'(irq), 32'(e_irq));
    check("oe", 32'(oe), 32'(e_oe));
    check("data_out", data_out, e_do);

    if (!rst) begin
`ifdef INTC_SYNC_EN
      rs = h1 & ~h2;
`else
      rs = src & ~h1;
`endif
      n_pend = m_pend; n_en = m_en; n_svc = m_svc; n_act = m_act;
      if (mem_wr && inr && off == 0) n_pend &= ~data_in[NSRC-1:0];
      if (mem_wr && inr && off == 1) n_en = data_in[NSRC-1:0];
      if (mem_rd && inr && off == 2 && !m_svc && any) begin
        n_pend[win] = 1'b0; n_svc = 1'b1; n_act = 5'(win + 1);
      end
      if (mem_wr && inr && off == 2 && m_svc && data_in[4:0] == m_act) begin
        n_svc = 1'b0; n_act = '0;
      end
      n_pend |= rs;
      h2 = h1; h1 = src;
      m_pend = n_pend; m_en = n_en; m_svc = n_svc; m_act = n_act;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bus cycle; optional literal check of read data at mid-cycle
  task automatic bus(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input bit chk, input logic [31:0] want,
                     input string name);
    mem_rd = rd; mem_wr = wr; addr = a; data_in = d;
    @(negedge clk);
    if (chk) check(name, data_out, want);
    @(posedge clk);
    #1;
    mem_rd = 1'b0; mem_wr = 1'b0; addr = '0; data_in = '0;
  endtask

  initial begin
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);

    // Basic flow
    bus(0, 1, BASE + 1, 32'h5, 0, 0, "");
    src[2] = 1'b1;
    tick(LAT - 1);
    check("irq_before_latency", 32'(irq), 32'd0);
    tick(1);
    check("irq_at_latency", 32'(irq), 32'd1);
    src[2] = 1'b0;
    bus(1, 0, BASE + 2, 0, 1, 32'd3, "claim_src2");
    bus(1, 0, BASE + 0, 0, 1, 32'd0, "pending_after_claim");
    bus(1, 0, BASE + 3, 0, 1, 32'h301, "status_in_service");
    check("irq_in_service", 32'(irq), 32'd0);
    bus(0, 1, BASE + 2, 32'd3, 0, 0, "");
    bus(1, 0, BASE + 3, 0, 1, 32'd0, "status_after_complete");
    check("irq_after_complete", 32'(irq), 32'd0);

    // Priority
    bus(0, 1, BASE + 1, 32'hFFFF, 0, 0, "");
    src[4] = 1'b1; src[1] = 1'b1;
    tick(LAT);
    src = '0;
    bus(1, 0, BASE + 2, 0, 1, 32'd2, "claim_prio_first");
    bus(0, 1, BASE + 2, 32'd2, 0, 0, "");
    bus(1, 0, BASE + 2, 0, 1, 32'd5, "claim_prio_second");
    bus(0, 1, BASE + 2, 32'd5, 0, 0, "");

    // Masking and W1C
    bus(0, 1, BASE + 1, 32'h0, 0, 0, "");
    src[7] = 1'b1;
    tick(LAT);
    src[7] = 1'b0;
    bus(1, 0, BASE + 0, 0, 1, 32'h80, "pending_masked");
    check("irq_masked", 32'(irq), 32'd0);
    bus(0, 1, BASE + 1, 32'h80, 0, 0, "");
    check("irq_unmasked", 32'(irq), 32'd1);
    bus(0, 1, BASE + 0, 32'h80, 0, 0, "");
    check("irq_after_w1c", 32'(irq), 32'd0);
    bus(1, 0, BASE + 0, 0, 1, 32'd0, "pending_after_w1c");

    // Collision: edge on bit0 in the same cycle as its W1C
    src[0] = 1'b1;
    tick(LAT);
    src[0] = 1'b0;
    tick(LAT + 1);
    src[0] = 1'b1;
    tick(LAT - 1);
    bus(0, 1, BASE + 0, 32'h1, 0, 0, "");
    src[0] = 1'b0;
    bus(1, 0, BASE + 0, 0, 1, 32'h1, "pending_set_wins");

    // Mismatched complete
    bus(0, 1, BASE + 1, 32'h1, 0, 0, "");
    bus(1, 0, BASE + 2, 0, 1, 32'd1, "claim_src0");
    bus(0, 1, BASE + 2, 32'd9, 0, 0, "");
    bus(1, 0, BASE + 3, 0, 1, 32'h101, "status_mismatch_ignored");
    bus(0, 1, BASE + 2, 32'd1, 0, 0, "");
    bus(1, 0, BASE + 3, 0, 1, 32'd0, "status_completed");

    // Bus isolation
    bus(1, 0, BASE + 4, 0, 1, 32'd0, "oob_high_data");
    bus(1, 0, BASE - 1, 0, 1, 32'd0, "oob_low_data");
    bus(0, 1, BASE + 4, 32'hFFFF, 0, 0, "");
    bus(0, 1, BASE - 1, 32'hFFFF, 0, 0, "");
    bus(1, 0, BASE + 1, 0, 1, 32'h1, "enable_untouched");

    // Reset mid-service, checked between edges without a clock
    bus(0, 1, BASE + 1, 32'h4, 0, 0, "");
    src[2] = 1'b1;
    tick(LAT);
    src[2] = 1'b0;
    bus(1, 0, BASE + 2, 0, 1, 32'd3, "claim_before_reset");
    #1 rst = 1'b1;
    #1 check("irq_in_reset", 32'(irq), 32'd0);
    mem_rd = 1'b1; addr = BASE + 3;
    #1 check("status_in_reset", data_out, 32'd0);
    addr = BASE + 1;
    #1 check("enable_in_reset", data_out, 32'd0);
    mem_rd = 1'b0; addr = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    tick(1);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int op, sel;
      src     = src ^ (NSRC'($urandom) & NSRC'($urandom) & NSRC'($urandom));
      op      = $urandom_range(0, 3);
      sel     = $urandom_range(0, 5);
      addr    = BASE + 32'(sel) - 32'd1;
      data_in = $urandom;
      if (sel == 3 && $urandom_range(0, 1) == 1) data_in[4:0] = m_act;
      if (sel == 1 && $urandom_range(0, 3) == 0) data_in = $urandom & 32'h1;
      mem_rd  = (op == 1 || op == 3);
      mem_wr  = (op == 2 || op == 3);
      tick(1);
    end
    mem_rd = 1'b0; mem_wr = 1'b0; src = '0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
